param_alu_dut: RTL and testbench



---
 rtl/param_alu_dut.sv | 208 ++++++++++++++++++++
 tb/tb_param_alu_dut.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_alu_dut.sv
// param_alu_dut: register-addressed A/B input FIFOs combined by a runtime-selected ALU op into a
// result FIFO. Define ALU_DUT_LEVEL_EN to expose A and Y occupancy on read addresses 6 and 7.

module param_alu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign count   = wr_ptr - rd_ptr;
  assign push_ok = push && (count != FULL_COUNT);
  assign pop_ok  = pop && (count != '0);
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

module param_alu_dut #(
  parameter int WIDTH     = 8,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             write_en,
  input  logic [2:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  output logic             write_rdy,
  input  logic             read_en,
  input  logic [2:0]       read_address,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy
);
  typedef enum logic [1:0] {
    OP_XOR = 2'd0,
    OP_AND = 2'd1,
    OP_OR  = 2'd2,
    OP_ADD = 2'd3
  } alu_op_e;

  localparam logic [2:0] WADDR_A   = 3'd4;
  localparam logic [2:0] WADDR_B   = 3'd5;
  localparam logic [2:0] WADDR_OP  = 3'd6;
  localparam logic [2:0] RADDR_Y   = 3'd3;
  localparam logic [2:0] RADDR_ERR = 3'd4;

  localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

  logic [IN_CW-1:0]  a_count;
  logic [IN_CW-1:0]  b_count;
  logic [OUT_CW-1:0] y_count;
  logic [WIDTH-1:0]  a_head;
  logic [WIDTH-1:0]  b_head;
  logic [WIDTH-1:0]  y_head;
  logic [WIDTH-1:0]  alu_y;
  logic [WIDTH-1:0]  read_mux;

  logic a_full, b_full, y_full;
  logic a_empty, b_empty, y_empty;
  logic wr_a, wr_b, wr_op;
  logic rd_y, rd_err;
  logic compute;
  logic y_pop;
  logic overflow_event, underflow_event;
  logic overflow_q, underflow_q;
  alu_op_e op_q;

  assign a_full  = (a_count == IN_CW'(IN_DEPTH));
  assign b_full  = (b_count == IN_CW'(IN_DEPTH));
  assign y_full  = (y_count == OUT_CW'(OUT_DEPTH));
  assign a_empty = (a_count == '0);
  assign b_empty = (b_count == '0);
  assign y_empty = (y_count == '0);

  assign wr_a   = write_en && (write_address == WADDR_A);
  assign wr_b   = write_en && (write_address == WADDR_B);
  assign wr_op  = write_en && (write_address == WADDR_OP);
  assign rd_y   = read_en && (read_address == RADDR_Y);
  assign rd_err = read_en && (read_address == RADDR_ERR);

  // A result pops Y before compute may refill it: a full Y stalls compute for that cycle.
  assign compute = !a_empty && !b_empty && !y_full;
  assign y_pop   = rd_y && !y_empty;

  assign overflow_event  = (wr_a && a_full) || (wr_b && b_full);
  assign underflow_event = rd_y && y_empty;

  always_comb begin
    write_rdy = 1'b1;
    if (write_address == WADDR_A)      write_rdy = !a_full;
    else if (write_address == WADDR_B) write_rdy = !b_full;
  end

  param_alu_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_fifo_a (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr_a),
    .push_data (write_data),
    .pop       (compute),
    .head      (a_head),
    .count     (a_count)
  );

  param_alu_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) u_fifo_b (
    .CLK       (CLK),
    .RST       (RST),
    .push      (wr_b),
    .push_data (write_data),
    .pop       (compute),
    .head      (b_head),
    .count     (b_count)
  );

  param_alu_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_fifo_y (
    .CLK       (CLK),
    .RST       (RST),
    .push      (compute),
    .push_data (alu_y),
    .pop       (y_pop),
    .head      (y_head),
    .count     (y_count)
  );

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    alu_y = '0;
    unique case (op_q)
      OP_XOR: alu_y = a_head ^ b_head;
      OP_AND: alu_y = a_head & b_head;
      OP_OR:  alu_y = a_head | b_head;
      OP_ADD: alu_y = a_head + b_head;
    endcase
  end

  always_comb begin
    read_mux = '0;
    case (read_address)
      3'd0: read_mux = WIDTH'(!a_full);
      3'd1: read_mux = WIDTH'(!b_full);
      3'd2: read_mux = WIDTH'(!y_empty);
      3'd3: read_mux = y_empty ? '0 : y_head;
      3'd4: read_mux = WIDTH'({underflow_q, overflow_q});
      3'd5: read_mux = WIDTH'(op_q);
`ifdef ALU_DUT_LEVEL_EN
      3'd6: read_mux = WIDTH'(a_count);
      3'd7: read_mux = WIDTH'(y_count);
`endif
      default: read_mux = '0;
    endcase
  end

  // A new error event on the same edge as the clearing read wins over the clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      op_q        <= OP_XOR;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_op) op_q <= alu_op_e'(write_data[1:0]);
      overflow_q  <= overflow_event  || (overflow_q  && !rd_err);
      underflow_q <= underflow_event || (underflow_q && !rd_err);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      read_data <= '0;
      read_rdy  <= 1'b0;
    end else begin
      read_rdy <= read_en;
      if (read_en) read_data <= read_mux;
    end
  end

endmodule

// File: tb/tb_param_alu_dut.sv
// Scoreboard bench for param_alu_dut: read expectations are queued when a read is driven and
// compared when read_rdy returns. Compile with ALU_DUT_LEVEL_EN to cover the occupancy reads.

module tb_param_alu_dut;
  localparam int W     = 8;
  localparam int IN_D  = 4;
  localparam int OUT_D = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         write_en = 1'b0;
  logic [2:0]   write_address = '0;
  logic [W-1:0] write_data = '0;
  logic         write_rdy;
  logic         read_en = 1'b0;
  logic [2:0]   read_address = '0;
  logic [W-1:0] read_data;
  logic         read_rdy;

  typedef struct {
    logic [W-1:0] val;
    string        nm;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] y_model[$];
  int           total = 0;
  int           bad = 0;
  logic         ren_d = 1'b0;

  param_alu_dut #(.WIDTH(W), .IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .write_en      (write_en),
    .write_address (write_address),
    .write_data    (write_data),
    .write_rdy     (write_rdy),
    .read_en       (read_en),
    .read_address  (read_address),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] alu_ref(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] s;
    case (op)
      2'd0:    s = a ^ b;
      2'd1:    s = a & b;
      2'd2:    s = a | b;
      default: s = a + b;
    endcase
    return s;
  endfunction

  // read_rdy must mirror the read_en seen at the previous rising edge.
  always @(posedge CLK or posedge RST) begin
    if (RST) ren_d <= 1'b0;
    else     ren_d <= read_en;
  end

  always @(negedge CLK) begin
    exp_t e;
    total++;
    if (read_rdy !== ren_d) begin
      bad++;
      $display("FAIL read_rdy_pulse got=%b want=%b t=%0t", read_rdy, ren_d, $time);
    end
    if (read_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read got=%h want=none t=%0t", read_data, $time);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (read_data !== e.val) begin
          bad++;
          $display("FAIL %s got=%h want=%h t=%0t", e.nm, read_data, e.val, $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d, input logic exp_rdy,
                    input string nm);
    @(negedge CLK);
    write_en = 1'b1; write_address = a; write_data = d;
    #1;
    total++;
    if (write_rdy !== exp_rdy) begin
      bad++;
      $display("FAIL %s write_rdy got=%b want=%b", nm, write_rdy, exp_rdy);
    end
    @(posedge CLK);
    #1 write_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [W-1:0] e, input string nm);
    exp_t x;
    @(negedge CLK);
    read_en = 1'b1; read_address = a;
    x.val = e; x.nm = nm;
    exp_q.push_back(x);
    @(posedge CLK);
    #1 read_en = 1'b0;
  endtask

  task automatic wr_rd(input logic [2:0] wa, input logic [W-1:0] wd, input logic exp_rdy,
                       input logic [2:0] ra, input logic [W-1:0] e, input string nm);
    exp_t x;
    @(negedge CLK);
    write_en = 1'b1; write_address = wa; write_data = wd;
    read_en = 1'b1;  read_address = ra;
    x.val = e; x.nm = nm;
    exp_q.push_back(x);
    #1;
    total++;
    if (write_rdy !== exp_rdy) begin
      bad++;
      $display("FAIL %s write_rdy got=%b want=%b", nm, write_rdy, exp_rdy);
    end
    @(posedge CLK);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++;
    if (read_data !== '0) begin
      bad++;
      $display("FAIL reset_read_data got=%h want=00", read_data);
    end
    total++;
    if (read_rdy !== 1'b0) begin
      bad++;
      $display("FAIL reset_read_rdy got=%b want=0", read_rdy);
    end
    @(negedge CLK);
    RST = 1'b0;
    rd(3'd0, 8'h01, "rst_a_not_full");
    rd(3'd1, 8'h01, "rst_b_not_full");
    rd(3'd2, 8'h00, "rst_y_not_empty");
    rd(3'd4, 8'h00, "rst_errors");
    rd(3'd5, 8'h00, "rst_op");
    rd(3'd6, 8'h00, "rst_a_level");
    rd(3'd7, 8'h00, "rst_y_level");
  endtask

  task automatic test_xor();
    wr(3'd4, 8'h5A, 1'b1, "xor_push_a");
    wr(3'd5, 8'h0F, 1'b1, "xor_push_b");
    idle(2);
    rd(3'd2, 8'h01, "xor_y_ready");
    rd(3'd3, 8'h55, "xor_result");
    idle(3);
    total++;
    if (read_data !== 8'h55) begin
      bad++;
      $display("FAIL read_data_hold got=%h want=55", read_data);
    end
    rd(3'd2, 8'h00, "xor_y_drained");
  endtask

  task automatic test_ops();
    wr(3'd6, 8'h03, 1'b1, "op_add_set");
    wr(3'd4, 8'hF0, 1'b1, "add_a");
    wr(3'd5, 8'h20, 1'b1, "add_b");
    idle(2);
    rd(3'd3, 8'h10, "add_carry_dropped");
    wr(3'd6, 8'h01, 1'b1, "op_and_set");
    wr(3'd4, 8'hF0, 1'b1, "and_a");
    wr(3'd5, 8'h3C, 1'b1, "and_b");
    idle(2);
    rd(3'd3, 8'h30, "and_result");
    wr(3'd6, 8'hFE, 1'b1, "op_or_set_upper_bits_ignored");
    wr(3'd4, 8'h81, 1'b1, "or_a");
    wr(3'd5, 8'h18, 1'b1, "or_b");
    idle(2);
    rd(3'd3, 8'h99, "or_result");
    rd(3'd5, 8'h02, "op_readback");
    wr(3'd0, 8'hFF, 1'b1, "ignored_addr0");
    wr(3'd7, 8'hFF, 1'b1, "ignored_addr7");
    rd(3'd5, 8'h02, "op_unchanged");
    rd(3'd2, 8'h00, "ignored_no_result");
    // op write lands on the compute edge, so the old XOR op must apply.
    wr(3'd6, 8'h00, 1'b1, "op_xor_set");
    wr(3'd4, 8'h0C, 1'b1, "late_op_a");
    wr(3'd5, 8'h0A, 1'b1, "late_op_b");
    wr(3'd6, 8'h01, 1'b1, "late_op_and");
    idle(2);
    rd(3'd3, 8'h06, "op_change_uses_old");
    rd(3'd5, 8'h01, "op_after_change");
  endtask

  task automatic test_overflow();
    for (int i = 0; i < IN_D; i++)
      wr(3'd4, W'(32'h11 * (i + 1)), 1'b1, "fill_a");
    wr(3'd4, 8'h55, 1'b0, "fill_a_full");
    rd(3'd0, 8'h00, "a_full_status");
    rd(3'd1, 8'h01, "b_not_full_status");
    rd(3'd4, 8'h01, "overflow_flag");
    rd(3'd4, 8'h00, "overflow_cleared");
    wr(3'd4, 8'h77, 1'b0, "overflow_again");
    wr_rd(3'd4, 8'h66, 1'b0, 3'd4, 8'h01, "clear_with_new_event");
    rd(3'd4, 8'h01, "new_event_survives_clear");
    rd(3'd4, 8'h00, "overflow_cleared_2");
  endtask

  task automatic test_underflow_drain();
    logic [W-1:0] b;
    rd(3'd3, 8'h00, "y_empty_read");
    rd(3'd4, 8'h02, "underflow_flag");
    rd(3'd4, 8'h00, "underflow_cleared");
    wr(3'd6, 8'h03, 1'b1, "drain_op_add");
    for (int i = 0; i < IN_D; i++) begin
      b = W'(32'h0F + 32'h2D * i);
      y_model.push_back(alu_ref(2'd3, W'(32'h11 * (i + 1)), b));
      wr(3'd5, b, 1'b1, "drain_push_b");
    end
    idle(2);
    for (int i = 0; i < IN_D; i++)
      rd(3'd3, y_model.pop_front(), "drain_result");
    rd(3'd2, 8'h00, "drain_no_extra_result");
    rd(3'd0, 8'h01, "drain_a_not_full");
    rd(3'd4, 8'h00, "drain_no_errors");
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < IN_D; i++)
      wr(3'd4, W'(i + 1), 1'b1, "ppf_fill_a");
    y_model.push_back(alu_ref(2'd3, 8'h01, 8'h10));
    wr(3'd5, 8'h10, 1'b1, "ppf_first_b");
    wr(3'd4, 8'h99, 1'b0, "ppf_push_on_pop_edge");
    rd(3'd4, 8'h01, "ppf_overflow");
    for (int i = 1; i < IN_D; i++) begin
      y_model.push_back(alu_ref(2'd3, W'(i + 1), W'(32'h10 * (i + 1))));
      wr(3'd5, W'(32'h10 * (i + 1)), 1'b1, "ppf_more_b");
    end
    idle(2);
    for (int i = 0; i < IN_D; i++)
      rd(3'd3, y_model.pop_front(), "ppf_result");
    rd(3'd2, 8'h00, "ppf_dropped_not_queued");
    rd(3'd0, 8'h01, "ppf_a_empty");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    wr(3'd6, 8'h00, 1'b1, "b2b_op_xor");
    for (int i = 0; i < OUT_D + 2; i++) begin
      a = W'(32'h20 + i);
      b = W'(32'hA0 + 3 * i);
      y_model.push_back(alu_ref(2'd0, a, b));
      wr(3'd4, a, 1'b1, "b2b_a");
      wr(3'd5, b, 1'b1, "b2b_b");
    end
    idle(3);
    rd(3'd0, 8'h01, "b2b_a_not_full");
    rd(3'd2, 8'h01, "b2b_y_not_empty");
`ifdef ALU_DUT_LEVEL_EN
    rd(3'd6, 8'h02, "b2b_a_level");
    rd(3'd7, W'(OUT_D), "b2b_y_level");
`else
    rd(3'd6, 8'h00, "b2b_addr6_zero");
    rd(3'd7, 8'h00, "b2b_addr7_zero");
`endif
    // First pop hits a full Y while A/B hold pairs: compute stalls, nothing is lost.
    for (int i = 0; i < OUT_D + 2; i++)
      rd(3'd3, y_model.pop_front(), "b2b_result");
    rd(3'd2, 8'h00, "b2b_y_drained");
    rd(3'd4, 8'h00, "b2b_no_errors");
  endtask

  task automatic test_reset_mid();
    wr(3'd4, 8'h01, 1'b1, "mid_a");
    wr(3'd5, 8'h02, 1'b1, "mid_b");
    idle(2);
    wr(3'd4, 8'h05, 1'b1, "mid_a_more");
    wr(3'd4, 8'h06, 1'b1, "mid_a_more");
    wr(3'd4, 8'h07, 1'b1, "mid_a_more");
`ifdef ALU_DUT_LEVEL_EN
    rd(3'd6, 8'h03, "mid_a_level");
    rd(3'd7, 8'h01, "mid_y_level");
`else
    rd(3'd6, 8'h00, "mid_addr6_zero");
    rd(3'd7, 8'h00, "mid_addr7_zero");
`endif
    rd(3'd2, 8'h01, "mid_y_not_empty");
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    total++;
    if (read_data !== '0 || read_rdy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got=%h/%b want=00/0", read_data, read_rdy);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    rd(3'd6, 8'h00, "post_rst_a_level");
    rd(3'd7, 8'h00, "post_rst_y_level");
    rd(3'd2, 8'h00, "post_rst_y_empty");
    rd(3'd0, 8'h01, "post_rst_a_not_full");
    rd(3'd5, 8'h00, "post_rst_op");
    rd(3'd4, 8'h00, "post_rst_errors");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_xor();
    test_ops();
    test_overflow();
    test_underflow_drain();
    test_push_pop_full();
    test_back_to_back();
    test_reset_mid();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_reads got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
